// File: rtl/pc_trace_monitor_pkg.sv
// rtl/pc_trace_monitor_pkg.sv - shared helpers and debug-bus field offsets for pc_trace_monitor
package pc_trace_monitor_pkg;

  localparam int DBG_FLAGS_LSB   = 0;
  localparam int DBG_FIRST_LSB   = 32;
  localparam int DBG_FIRST_VALID = 40;
  localparam int DBG_FROZEN_BIT  = 41;
  localparam int DBG_FILL_LSB    = 48;

  function automatic int slot_lsb(input int k, input int w);
    return k * w;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pc_trace_monitor_trace_ring.sv
// rtl/pc_trace_monitor_trace_ring.sv - ring buffer of recent EX PCs with age-indexed registered read
module trace_ring
  import pc_trace_monitor_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [PC_W-1:0]  wr_data,
  input  logic             rd_req,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [PC_W-1:0]  rd_data,
  output logic [IDX_W:0]   fill
);

  generate
    if (!is_pow2(DEPTH)) begin : g_depth_check
      $error("trace_ring DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [PC_W-1:0]  mem [DEPTH];
  logic [IDX_W-1:0] wptr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wr_data;
  end

  // Read uses the pre-edge wptr, so a same-cycle write never shows up in it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr     <= '0;
      fill     <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        if (clear || ({1'b0, rd_idx} >= fill)) rd_data <= '0;
        else rd_data <= mem[wptr - IDX_W'(1) - rd_idx];
      end
      if (clear) begin
        wptr <= '0;
        fill <= '0;
      end else if (wr_en) begin
        wptr <= wptr + IDX_W'(1);
        if (fill != (IDX_W + 1)'(DEPTH)) fill <= fill + (IDX_W + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/pc_trace_monitor.sv
// rtl/pc_trace_monitor.sv - EX-stage PC checkpoints, hit counters, first-hit record and freezing trace
module pc_trace_monitor
  import pc_trace_monitor_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int NUM_CHK     = 14,
  parameter int CNT_W       = 16,
  parameter int TRACE_DEPTH = 16,
  parameter int IDX_W       = $clog2(TRACE_DEPTH),
  parameter int SEL_W       = sel_width(NUM_CHK)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    pc_valid,
  input  logic [PC_W-1:0]         pc_ex,
  input  logic [NUM_CHK*PC_W-1:0] chk_pc,
  input  logic [NUM_CHK-1:0]      arm_mask,
  input  logic                    clear,
  output logic [NUM_CHK-1:0]      hit_flags,
  output logic                    first_hit_valid,
  output logic [SEL_W-1:0]        first_hit_idx,
  input  logic [SEL_W-1:0]        cnt_sel,
  output logic [CNT_W-1:0]        hit_cnt,
  output logic                    frozen,
  output logic [IDX_W:0]          trace_fill,
  input  logic                    rd_req,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic                    rd_valid,
  output logic [PC_W-1:0]         rd_data
);

  logic [NUM_CHK-1:0] match;
  logic [SEL_W-1:0]   low_idx;
  logic [CNT_W-1:0]   sel_cnt;
  logic [CNT_W-1:0]   cnt [NUM_CHK];
  logic               wr_en;

  always_comb begin
    match   = '0;
    low_idx = '0;
    sel_cnt = '0;
    for (int k = 0; k < NUM_CHK; k++) begin
      match[k] = pc_valid && (pc_ex == chk_pc[slot_lsb(k, PC_W) +: PC_W]);
      if (SEL_W'(k) == cnt_sel) sel_cnt = cnt[k];
    end
    for (int k = NUM_CHK - 1; k >= 0; k--) begin
      if (match[k]) low_idx = SEL_W'(k);
    end
  end

  assign wr_en = pc_valid && !frozen && !clear;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hit_flags       <= '0;
      first_hit_valid <= 1'b0;
      first_hit_idx   <= '0;
      hit_cnt         <= '0;
      frozen          <= 1'b0;
      for (int k = 0; k < NUM_CHK; k++) cnt[k] <= '0;
    end else if (clear) begin
      hit_flags       <= '0;
      first_hit_valid <= 1'b0;
      first_hit_idx   <= '0;
      hit_cnt         <= '0;
      frozen          <= 1'b0;
      for (int k = 0; k < NUM_CHK; k++) cnt[k] <= '0;
    end else begin
      hit_flags <= hit_flags | match;
      for (int k = 0; k < NUM_CHK; k++) begin
        if (match[k] && (cnt[k] != '1)) cnt[k] <= cnt[k] + CNT_W'(1);
      end
      if (|match && !first_hit_valid) begin
        first_hit_valid <= 1'b1;
        first_hit_idx   <= low_idx;
      end
      // The arming PC itself is still written this cycle; capture stops afterwards.
      if (|(match & arm_mask)) frozen <= 1'b1;
      hit_cnt <= sel_cnt;
    end
  end

  trace_ring #(
    .PC_W  (PC_W),
    .DEPTH (TRACE_DEPTH),
    .IDX_W (IDX_W)
  ) u_trace_ring (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (clear),
    .wr_en    (wr_en),
    .wr_data  (pc_ex),
    .rd_req   (rd_req),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .fill     (trace_fill)
  );

endmodule

// File: tb/tb_pc_trace_monitor.sv
// tb/tb_pc_trace_monitor.sv - directed self-checking bench for pc_trace_monitor
module tb_pc_trace_monitor;

  localparam int PC_W = 32;
  localparam int NUM_CHK = 14;
  localparam int CNT_W = 4;
  localparam int TRACE_DEPTH = 16;
  localparam int IDX_W = 4;
  localparam int SEL_W = 4;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic                    pc_valid;
  logic [PC_W-1:0]         pc_ex;
  logic [NUM_CHK*PC_W-1:0] chk_pc;
  logic [NUM_CHK-1:0]      arm_mask;
  logic                    clear;
  logic [NUM_CHK-1:0]      hit_flags;
  logic                    first_hit_valid;
  logic [SEL_W-1:0]        first_hit_idx;
  logic [SEL_W-1:0]        cnt_sel;
  logic [CNT_W-1:0]        hit_cnt;
  logic                    frozen;
  logic [IDX_W:0]          trace_fill;
  logic                    rd_req;
  logic [IDX_W-1:0]        rd_idx;
  logic                    rd_valid;
  logic [PC_W-1:0]         rd_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pc_trace_monitor #(
    .PC_W(PC_W), .NUM_CHK(NUM_CHK), .CNT_W(CNT_W), .TRACE_DEPTH(TRACE_DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn), .pc_valid(pc_valid), .pc_ex(pc_ex), .chk_pc(chk_pc),
    .arm_mask(arm_mask), .clear(clear), .hit_flags(hit_flags),
    .first_hit_valid(first_hit_valid), .first_hit_idx(first_hit_idx),
    .cnt_sel(cnt_sel), .hit_cnt(hit_cnt), .frozen(frozen), .trace_fill(trace_fill),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [PC_W-1:0] pc);
    pc_valid = 1'b1;
    pc_ex = pc;
    tick();
    pc_valid = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int idx, input logic [PC_W-1:0] exp);
    rd_req = 1'b1;
    rd_idx = IDX_W'(idx);
    tick();
    rd_req = 1'b0;
    expect_eq({tag, "_valid"}, 64'(rd_valid), 64'd1);
    expect_eq({tag, "_data"}, 64'(rd_data), 64'(exp));
  endtask

  task automatic cnt_chk(input string tag, input int sel, input int exp);
    cnt_sel = SEL_W'(sel);
    tick();
    expect_eq(tag, 64'(hit_cnt), 64'(exp));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; pc_valid = 1'b0; pc_ex = '0; arm_mask = '0; clear = 1'b0;
    cnt_sel = '0; rd_req = 1'b0; rd_idx = '0;
    for (int k = 0; k < NUM_CHK; k++) chk_pc[k*PC_W +: PC_W] = 32'hF000_0000 + k;
    chk_pc[0*PC_W +: PC_W] = 33580;
    chk_pc[3*PC_W +: PC_W] = 33580;
    chk_pc[1*PC_W +: PC_W] = 500;
    chk_pc[2*PC_W +: PC_W] = 7000;
    chk_pc[4*PC_W +: PC_W] = 502;
    chk_pc[5*PC_W +: PC_W] = 900;
    chk_pc[6*PC_W +: PC_W] = 900;
    tick(); tick();
    expect_eq("rst_flags", 64'(hit_flags), 0);
    expect_eq("rst_fhv", 64'(first_hit_valid), 0);
    expect_eq("rst_frozen", 64'(frozen), 0);
    expect_eq("rst_fill", 64'(trace_fill), 0);
    expect_eq("rst_rdv", 64'(rd_valid), 0);
    expect_eq("rst_cnt", 64'(hit_cnt), 0);
    rstn = 1'b1;
    tick();

    // duplicate checkpoint addresses both hit
    push(33580);
    expect_eq("dup_flags", 64'(hit_flags), 64'h0009);
    expect_eq("dup_fhv", 64'(first_hit_valid), 1);
    expect_eq("dup_fhi", 64'(first_hit_idx), 0);
    cnt_chk("dup_cnt0", 0, 1);
    cnt_chk("dup_cnt3", 3, 1);
    expect_eq("dup_fill", 64'(trace_fill), 1);

    // stall bubble
    pc_valid = 1'b0; pc_ex = 33704;
    tick();
    expect_eq("bub_flags", 64'(hit_flags), 64'h0009);
    expect_eq("bub_fill", 64'(trace_fill), 1);
    read_chk("bub_rd0", 0, 33580);

    // saturating counter
    for (int i = 0; i < 20; i++) push(7000);
    cnt_chk("sat_cnt2", 2, 15);
    cnt_chk("sat_hold", 2, 15);
    expect_eq("sat_flags", 64'(hit_flags), 64'h000D);
    expect_eq("sat_fhi", 64'(first_hit_idx), 0);

    do_clear();
    expect_eq("clr_flags", 64'(hit_flags), 0);
    expect_eq("clr_fhv", 64'(first_hit_valid), 0);
    expect_eq("clr_fill", 64'(trace_fill), 0);
    cnt_chk("clr_cnt2", 2, 0);

    // read beyond fill
    push(200);
    push(201);
    read_chk("oob_rd3", 3, 0);
    read_chk("fill2_rd0", 0, 201);
    read_chk("fill2_rd1", 1, 200);

    // wraparound
    do_clear();
    for (int i = 100; i < 120; i++) push(PC_W'(i));
    expect_eq("wrap_fill", 64'(trace_fill), 16);
    read_chk("wrap_rd0", 0, 119);
    read_chk("wrap_rd15", 15, 104);
    read_chk("wrap_rd1", 1, 118);
    pc_valid = 1'b1; pc_ex = 120; rd_req = 1'b1; rd_idx = 0;
    tick();
    pc_valid = 1'b0; rd_req = 1'b0;
    expect_eq("rdwr_data", 64'(rd_data), 119);
    read_chk("rdwr_after", 0, 120);
    read_chk("rdwr_old15", 15, 105);

    // freeze on armed checkpoint
    do_clear();
    arm_mask = NUM_CHK'(2);
    push(498);
    push(499);
    expect_eq("frz_before", 64'(frozen), 0);
    push(500);
    expect_eq("frz_after", 64'(frozen), 1);
    push(501);
    push(502);
    push(500);
    expect_eq("frz_fill", 64'(trace_fill), 3);
    expect_eq("frz_flags", 64'(hit_flags), 64'h0012);
    expect_eq("frz_fhi", 64'(first_hit_idx), 1);
    read_chk("frz_rd0", 0, 500);
    read_chk("frz_rd1", 1, 499);
    read_chk("frz_rd3", 3, 0);
    cnt_chk("frz_cnt1", 1, 2);
    cnt_chk("frz_cnt4", 4, 1);

    // clear beats a simultaneous match, write and read
    arm_mask = '0;
    clear = 1'b1; pc_valid = 1'b1; pc_ex = 33580; rd_req = 1'b1; rd_idx = 0;
    tick();
    clear = 1'b0; pc_valid = 1'b0; rd_req = 1'b0;
    expect_eq("cm_flags", 64'(hit_flags), 0);
    expect_eq("cm_fhv", 64'(first_hit_valid), 0);
    expect_eq("cm_fill", 64'(trace_fill), 0);
    expect_eq("cm_frozen", 64'(frozen), 0);
    expect_eq("cm_rdv", 64'(rd_valid), 1);
    expect_eq("cm_rdd", 64'(rd_data), 0);
    cnt_chk("cm_cnt0", 0, 0);

    // first hit picks lowest simultaneous index and then holds
    push(900);
    expect_eq("fh_idx5", 64'(first_hit_idx), 5);
    expect_eq("fh_flags", 64'(hit_flags), 64'h0060);
    push(33580);
    expect_eq("fh_hold", 64'(first_hit_idx), 5);

    // reset in the middle of a read
    rd_req = 1'b1; rd_idx = 0;
    tick();
    rd_req = 1'b0;
    expect_eq("mid_rdv_pre", 64'(rd_valid), 1);
    rstn = 1'b0;
    #1;
    expect_eq("mid_rdv_rst", 64'(rd_valid), 0);
    tick();
    expect_eq("mid_rdv_post", 64'(rd_valid), 0);
    expect_eq("mid_fill", 64'(trace_fill), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
